fft8_out_serializer: RTL and testbench

//  Downstream stage of the 8-point FFT core. Captures the eight parallel result words on the core's
//  one-cycle done pulse. Streams them one per beat over a valid/ready interface.

---
 rtl/fft8_pkg.sv | 29 ++
 rtl/fft8_abs_sat.sv | 26 ++
 rtl/fft8_out_serializer.sv | 160 ++++++++++++++++
 tb/tb_fft8_out_serializer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft8_pkg
//  Purpose  : Shared constants, state encoding and index helpers for the
//             8-point FFT core and its output stages.
//  Revision : 1.0  initial release
// ============================================================================
package fft8_pkg;

    localparam int FFT_N      = 8;
    localparam int FFT_LOG2N  = 3;
    localparam int DW_DEFAULT = 16;

    localparam logic [FFT_LOG2N-1:0] CNT_LAST = FFT_LOG2N'(FFT_N - 1);

    localparam logic [0:0] IDLE_ENC = 1'b0;
    localparam logic [0:0] SEND_ENC = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = IDLE_ENC,
        ST_SEND = SEND_ENC
    } state_e;

    function automatic logic [FFT_LOG2N-1:0] bitrev3(input logic [FFT_LOG2N-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage : fft8_pkg
`default_nettype wire

// File: rtl/fft8_abs_sat.sv
`default_nettype none
// ============================================================================
//  Module   : fft8_abs_sat
//  Purpose  : Combinational saturating magnitude of a signed word; the most
//             negative input maps to the largest positive value.
//  Revision : 1.0  initial release
// ============================================================================
module fft8_abs_sat #(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0] x_i,
    output logic        [DW-1:0] abs_o
);

    localparam logic [DW-1:0] C_MIN_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] C_MAX_POS = {1'b0, {(DW-1){1'b1}}};

    always_comb begin
        abs_o = x_i;
        if (x_i[DW-1]) begin
            abs_o = (x_i == C_MIN_NEG) ? C_MAX_POS : -x_i;
        end
    end

endmodule : fft8_abs_sat
`default_nettype wire

// File: rtl/fft8_out_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : fft8_out_serializer
//  Purpose  : Captures an 8-bin FFT frame on done_in, streams it one bin per
//             valid/ready beat and reports the frame's peak magnitude.
//  Revision : 1.0  initial release
// ============================================================================
module fft8_out_serializer
    import fft8_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter bit BITREV = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        done_in,
    input  logic signed [DW-1:0]        data_in0,
    input  logic signed [DW-1:0]        data_in1,
    input  logic signed [DW-1:0]        data_in2,
    input  logic signed [DW-1:0]        data_in3,
    input  logic signed [DW-1:0]        data_in4,
    input  logic signed [DW-1:0]        data_in5,
    input  logic signed [DW-1:0]        data_in6,
    input  logic signed [DW-1:0]        data_in7,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic signed [DW-1:0]        m_data,
    output logic        [FFT_LOG2N-1:0] m_index,
    output logic                        m_last,
    output logic                        busy,
    output logic                        overrun,
    output logic                        peak_valid,
    output logic        [DW-1:0]        peak_abs,
    output logic        [FFT_LOG2N-1:0] peak_idx
);

    logic [DW-1:0]        w_din [FFT_N];
    logic [DW-1:0]        buf_q [FFT_N];
    logic [DW-1:0]        buf_d [FFT_N];
    state_e               state_q, state_d;
    logic [FFT_LOG2N-1:0] cnt_q, cnt_d;
    logic [DW-1:0]        run_peak_q, run_peak_d;
    logic [FFT_LOG2N-1:0] run_idx_q, run_idx_d;
    logic                 peak_valid_q, peak_valid_d;
    logic [DW-1:0]        peak_abs_q, peak_abs_d;
    logic [FFT_LOG2N-1:0] peak_idx_q, peak_idx_d;
    logic                 overrun_q, overrun_d;

    logic [FFT_LOG2N-1:0] w_order;
    logic [DW-1:0]        w_beat;
    logic [DW-1:0]        w_abs;
    logic                 w_send, w_accept, w_last_acc, w_capture, w_peak_gt;

    assign w_din[0] = data_in0;
    assign w_din[1] = data_in1;
    assign w_din[2] = data_in2;
    assign w_din[3] = data_in3;
    assign w_din[4] = data_in4;
    assign w_din[5] = data_in5;
    assign w_din[6] = data_in6;
    assign w_din[7] = data_in7;

    generate
        if (BITREV) begin : g_bitrev
            assign w_order = bitrev3(cnt_q);
        end else begin : g_natural
            assign w_order = cnt_q;
        end
    endgenerate

    assign w_send     = (state_q == ST_SEND);
    assign w_beat     = buf_q[w_order];
    assign w_accept   = w_send & m_ready;
    assign w_last_acc = w_accept & (cnt_q == CNT_LAST);
    // A strobe landing on the accepted last beat starts the next frame back-to-back.
    assign w_capture  = done_in & (~w_send | w_last_acc);
    assign w_peak_gt  = (w_abs > run_peak_q);

    fft8_abs_sat #(
        .DW (DW)
    ) u_abs (
        .x_i   (w_beat),
        .abs_o (w_abs)
    );

    assign m_valid    = w_send;
    assign busy       = w_send;
    assign m_data     = w_send ? w_beat : '0;
    assign m_index    = w_send ? w_order : '0;
    assign m_last     = w_send & (cnt_q == CNT_LAST);
    assign overrun    = overrun_q;
    assign peak_valid = peak_valid_q;
    assign peak_abs   = peak_abs_q;
    assign peak_idx   = peak_idx_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        run_peak_d   = run_peak_q;
        run_idx_d    = run_idx_q;
        peak_valid_d = 1'b0;
        peak_abs_d   = peak_abs_q;
        peak_idx_d   = peak_idx_q;
        overrun_d    = done_in & ~w_capture;

        if (w_accept) begin
            cnt_d = cnt_q + 1'b1;
            if (w_peak_gt) begin
                run_peak_d = w_abs;
                run_idx_d  = w_order;
            end
            if (w_last_acc) begin
                state_d      = ST_IDLE;
                peak_valid_d = 1'b1;
                peak_abs_d   = w_peak_gt ? w_abs : run_peak_q;
                peak_idx_d   = w_peak_gt ? w_order : run_idx_q;
            end
        end

        // Bin 0 is emitted first in both orderings, so it seeds the peak index.
        if (w_capture) begin
            state_d    = ST_SEND;
            buf_d      = w_din;
            cnt_d      = '0;
            run_peak_d = '0;
            run_idx_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            run_peak_q   <= '0;
            run_idx_q    <= '0;
            peak_valid_q <= 1'b0;
            peak_abs_q   <= '0;
            peak_idx_q   <= '0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < FFT_N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_peak_q   <= run_peak_d;
            run_idx_q    <= run_idx_d;
            peak_valid_q <= peak_valid_d;
            peak_abs_q   <= peak_abs_d;
            peak_idx_q   <= peak_idx_d;
            overrun_q    <= overrun_d;
            for (int i = 0; i < FFT_N; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule : fft8_out_serializer
`default_nettype wire

// File: tb/tb_fft8_out_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft8_out_serializer
//  Purpose  : Scoreboard bench driving natural-order and bit-reversed
//             serializers with identical stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft8_out_serializer;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [15:0] abs_v;
        logic [2:0]  idx;
    } peak_t;

    logic        clk;
    logic        rst;
    logic        done_in;
    logic        m_ready;
    logic [15:0] fr [8];

    logic        mv  [2];
    logic [15:0] md  [2];
    logic [2:0]  mi  [2];
    logic        ml  [2];
    logic        bsy [2];
    logic        ovr [2];
    logic        pv  [2];
    logic [15:0] pa  [2];
    logic [2:0]  pi  [2];

    beat_t bq0[$], bq1[$];
    peak_t pq0[$], pq1[$];

    int total = 0;
    int bad   = 0;
    int rem   = 0;
    bit pend_ovr = 1'b0;

    fft8_out_serializer #(.DW(16), .BITREV(1'b0)) u_nat (
        .clk(clk), .rst(rst), .done_in(done_in),
        .data_in0(fr[0]), .data_in1(fr[1]), .data_in2(fr[2]), .data_in3(fr[3]),
        .data_in4(fr[4]), .data_in5(fr[5]), .data_in6(fr[6]), .data_in7(fr[7]),
        .m_valid(mv[0]), .m_ready(m_ready), .m_data(md[0]), .m_index(mi[0]),
        .m_last(ml[0]), .busy(bsy[0]), .overrun(ovr[0]), .peak_valid(pv[0]),
        .peak_abs(pa[0]), .peak_idx(pi[0])
    );

    fft8_out_serializer #(.DW(16), .BITREV(1'b1)) u_rev (
        .clk(clk), .rst(rst), .done_in(done_in),
        .data_in0(fr[0]), .data_in1(fr[1]), .data_in2(fr[2]), .data_in3(fr[3]),
        .data_in4(fr[4]), .data_in5(fr[5]), .data_in6(fr[6]), .data_in7(fr[7]),
        .m_valid(mv[1]), .m_ready(m_ready), .m_data(md[1]), .m_index(mi[1]),
        .m_last(ml[1]), .busy(bsy[1]), .overrun(ovr[1]), .peak_valid(pv[1]),
        .peak_abs(pa[1]), .peak_idx(pi[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int sabs(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    // Emission position j -> bin number for instance d (1 = bit-reversed).
    function automatic int order(input int d, input int j);
        if (d == 0) return j;
        return ((j % 2) * 4) + (((j / 2) % 2) * 2) + (j / 4);
    endfunction

    task automatic push_frame();
        beat_t b;
        peak_t p;
        int best, bidx, k, a;
        for (int d = 0; d < 2; d++) begin
            best = 0;
            bidx = order(d, 0);
            for (int j = 0; j < 8; j++) begin
                k = order(d, j);
                b.data = fr[k];
                b.idx  = 3'(k);
                b.last = (j == 7);
                if (d == 0) bq0.push_back(b); else bq1.push_back(b);
                a = sabs(fr[k]);
                if (a > best) begin
                    best = a;
                    bidx = k;
                end
            end
            p.abs_v = 16'(best);
            p.idx   = 3'(bidx);
            if (d == 0) pq0.push_back(p); else pq1.push_back(p);
        end
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input bit dn, input bit rdy);
        bit acc, lastacc;
        for (int d = 0; d < 2; d++) begin
            chk(mv[d] == (rem > 0), $sformatf("m_valid_dut%0d", d), mv[d], rem > 0);
            chk(bsy[d] == (rem > 0), $sformatf("busy_dut%0d", d), bsy[d], rem > 0);
            chk(ovr[d] == pend_ovr, $sformatf("overrun_dut%0d", d), ovr[d], pend_ovr);
        end
        done_in  = dn;
        m_ready  = rdy;
        acc      = (rem > 0) && rdy;
        lastacc  = acc && (rem == 1);
        pend_ovr = 1'b0;
        if (acc) rem--;
        if (dn) begin
            if ((rem == 0) || lastacc) begin
                push_frame();
                rem = 8;
            end else begin
                pend_ovr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            if (rem == 0 && !pend_ovr && bq0.size() == 0 && bq1.size() == 0 &&
                pq0.size() == 0 && pq1.size() == 0) break;
            step(1'b0, 1'b1);
        end
        chk(bq0.size() + bq1.size() + pq0.size() + pq1.size() == 0, "drain_pending",
            bq0.size() + bq1.size() + pq0.size() + pq1.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({mv[d], bsy[d], ml[d], ovr[d], pv[d]} == 5'b0, $sformatf("%s_flags_dut%0d", tag, d),
                {mv[d], bsy[d], ml[d], ovr[d], pv[d]}, 0);
            chk(md[d] == 16'd0, $sformatf("%s_m_data_dut%0d", tag, d), md[d], 0);
            chk(mi[d] == 3'd0, $sformatf("%s_m_index_dut%0d", tag, d), mi[d], 0);
            chk(pa[d] == 16'd0, $sformatf("%s_peak_abs_dut%0d", tag, d), pa[d], 0);
            chk(pi[d] == 3'd0, $sformatf("%s_peak_idx_dut%0d", tag, d), pi[d], 0);
        end
    endtask

    task automatic mon(input int d);
        beat_t e;
        peak_t p;
        int    n;
        if (mv[d]) begin
            n = (d == 0) ? bq0.size() : bq1.size();
            if (n == 0) begin
                chk(1'b0, $sformatf("unexpected_beat_dut%0d", d), md[d], 0);
            end else begin
                e = (d == 0) ? bq0[0] : bq1[0];
                chk(md[d] == e.data, $sformatf("beat_data_dut%0d", d), md[d], e.data);
                chk(mi[d] == e.idx, $sformatf("beat_index_dut%0d", d), mi[d], e.idx);
                chk(ml[d] == e.last, $sformatf("beat_last_dut%0d", d), ml[d], e.last);
                if (m_ready) begin
                    if (d == 0) void'(bq0.pop_front()); else void'(bq1.pop_front());
                end
            end
        end
        if (pv[d]) begin
            n = (d == 0) ? pq0.size() : pq1.size();
            if (n == 0) begin
                chk(1'b0, $sformatf("unexpected_peak_dut%0d", d), pa[d], 0);
            end else begin
                p = (d == 0) ? pq0.pop_front() : pq1.pop_front();
                chk(pa[d] == p.abs_v, $sformatf("peak_abs_dut%0d", d), pa[d], p.abs_v);
                chk(pi[d] == p.idx, $sformatf("peak_idx_dut%0d", d), pi[d], p.idx);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) mon(d);
        end
    end

    initial begin
        rst     = 1'b1;
        done_in = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fr[i] = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ramp frame at full rate, both orderings
        for (int i = 0; i < 8; i++) fr[i] = 16'(i);
        step(1'b1, 1'b1);
        drain();

        // Saturation and ties under alternating back-pressure
        fr[0] = 16'd5;      fr[1] = 16'hFFF7; fr[2] = 16'd3; fr[3] = 16'h8000;
        fr[4] = 16'd9;      fr[5] = 16'd0;    fr[6] = 16'd0; fr[7] = 16'd0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 24; i++) step(1'b0, (i % 2) == 0);
        drain();

        // Strobe coincident with the accepted last beat
        for (int i = 0; i < 8; i++) fr[i] = 16'(100 * i + 1);
        step(1'b1, 1'b1);
        while (rem != 1) step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) fr[i] = 16'(-(i * 37));
        step(1'b1, 1'b1);
        drain();

        // Strobe mid-frame is dropped with an overrun pulse
        for (int i = 0; i < 8; i++) fr[i] = 16'(i * 11 + 2);
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) fr[i] = 16'h7000 + 16'(i);
        step(1'b1, 1'b1);
        drain();

        // Reset during beat 4 discards the frame
        for (int i = 0; i < 8; i++) fr[i] = 16'(i + 20);
        step(1'b1, 1'b1);
        while (rem != 4) step(1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk_zero("midreset");
        bq0.delete(); bq1.delete(); pq0.delete(); pq1.delete();
        rem      = 0;
        pend_ovr = 1'b0;
        done_in  = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) fr[i] = 16'(3 * i + 1);
        step(1'b1, 1'b1);
        drain();

        // Randomized strobes, data and back-pressure
        for (int c = 0; c < 500; c++) begin
            bit dn;
            dn = ($urandom_range(0, 5) == 0);
            if (dn) begin
                for (int i = 0; i < 8; i++)
                    fr[i] = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
            end
            step(dn, $urandom_range(0, 9) < 7);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule : tb_fft8_out_serializer
`default_nettype wire
